// File: rtl/exec_datapath_pkg.sv
// Shared definitions for the execution datapath: default widths and ALU opcodes.
// Opcodes 4'hC..4'hF are undefined and give a zero result with carry clear.
package exec_datapath_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_BITS_DEF  = 5;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_SHR   = 4'h7;
  localparam logic [3:0] OP_INC   = 4'h8;
  localparam logic [3:0] OP_DEC   = 4'h9;
  localparam logic [3:0] OP_PASSA = 4'hA;
  localparam logic [3:0] OP_PASSB = 4'hB;
  localparam logic [3:0] OP_NOP   = 4'hF;

endpackage

// File: rtl/exec_datapath_alu_core.sv
// Combinational ALU for the execution datapath.
// For subtract and decrement, carry is the borrow out of the top bit.
module alu_core
  import exec_datapath_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   opcode,
  output logic [W-1:0] y,
  output logic         carry
);

  logic [W:0] sum_w;
  logic [W:0] diff_w;
  logic [W:0] inc_w;
  logic [W:0] dec_w;

  // Widen by one bit so that the carry or borrow falls into the MSB.
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign inc_w  = {1'b0, a} + {{W{1'b0}}, 1'b1};
  assign dec_w  = {1'b0, a} - {{W{1'b0}}, 1'b1};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (opcode)
      OP_ADD:   {carry, y} = sum_w;
      OP_SUB:   {carry, y} = diff_w;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOT:   y = ~a;
      OP_SHL: begin
        y     = {a[W-2:0], 1'b0};
        carry = a[W-1];
      end
      OP_SHR: begin
        y     = {1'b0, a[W-1:1]};
        carry = a[0];
      end
      OP_INC:   {carry, y} = inc_w;
      OP_DEC:   {carry, y} = dec_w;
      OP_PASSA: y = a;
      OP_PASSB: y = b;
      default: begin
        y     = '0;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exec_datapath.sv
// Execution datapath: a registered ALU stage feeds the data memory address, a synchronous
// read-before-write memory stage, and the write-back select mux driving result2.
module exec_datapath
  import exec_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_d,   alu_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic [DATA_WIDTH-1:0] mem_d,   mem_q;
  logic                  we_d,    we_q;
  logic                  zero_d,  zero_q;
  logic                  carry_d, carry_q;
  logic [ADDR_BITS-1:0]  addr;
  logic [DATA_WIDTH-1:0] ram_d [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  assign alu_b = sel3 ? offset : operand2;

  alu_core #(
    .W(DATA_WIDTH)
  ) u_alu (
    .a      (operand1),
    .b      (alu_b),
    .opcode (opcode),
    .y      (alu_d),
    .carry  (carry_d)
  );

  // Only the low address bits are used, so high ALU bits wrap onto the same words.
  assign addr = alu_q[ADDR_BITS-1:0];

  always_comb begin
    zero_d  = (alu_d == '0);
    wdata_d = operand2;
    we_d    = w_r;
    mem_d   = ram_q[addr];
    ram_d   = ram_q;
    if (we_q) begin
      ram_d[addr] = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      mem_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ram_q[i] <= '0;
      end
    end else begin
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      mem_q   <= mem_d;
      ram_q   <= ram_d;
    end
  end

  assign result2 = sel1 ? alu_q : mem_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Randomized and directed bench for exec_datapath against an arithmetic reference model.
module tb_exec_datapath;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_PASSA = 4'hA;
  localparam logic [3:0] OP_NOP   = 4'hF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] operand1 = '0;
  logic [7:0] operand2 = '0;
  logic [7:0] offset = '0;
  logic [3:0] opcode = '0;
  logic       sel1 = 1'b0;
  logic       sel3 = 1'b0;
  logic       w_r = 1'b0;
  logic [7:0] result2;
  logic       zero;
  logic       carry;

  int compared = 0;
  int mismatched = 0;
  bit check_en = 1'b0;

  // Reference model state: last ALU result and flags, pending store, last memory read, memory image.
  int m_alu = 0;
  int m_rd = 0;
  int m_wdata = 0;
  bit m_we = 1'b0;
  bit m_zero = 1'b0;
  bit m_carry = 1'b0;
  int m_mem [32];
  int s_addr, s_old, s_y;
  bit s_c;

  always #5 clk = ~clk;

  exec_datapath dut (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .offset   (offset),
    .opcode   (opcode),
    .sel1     (sel1),
    .sel3     (sel3),
    .w_r      (w_r),
    .result2  (result2),
    .zero     (zero),
    .carry    (carry)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] off,
                               input logic [3:0] op, input logic s1, input logic s3, input logic wr);
    operand1 = a;
    operand2 = b;
    offset   = off;
    opcode   = op;
    sel1     = s1;
    sel3     = s3;
    w_r      = wr;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic void refAlu(input int a, input int b, input int op, output int y, output bit c);
    int s;
    y = 0;
    c = 1'b0;
    case (op)
      0:  begin s = a + b; y = s % 256; c = (s >= 256); end
      1:  begin y = (a - b + 256) % 256; c = (a < b); end
      2:  y = a & b;
      3:  y = a | b;
      4:  y = a ^ b;
      5:  y = 255 - a;
      6:  begin y = (a * 2) % 256; c = (a >= 128); end
      7:  begin y = a / 2; c = (a % 2 == 1); end
      8:  begin y = (a + 1) % 256; c = (a == 255); end
      9:  begin y = (a + 255) % 256; c = (a == 0); end
      10: y = a;
      11: y = b;
      default: begin y = 0; c = 1'b0; end
    endcase
  endfunction

  always @(posedge rst) begin
    m_alu = 0; m_rd = 0; m_wdata = 0; m_we = 1'b0; m_zero = 1'b0; m_carry = 1'b0;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      s_addr = m_alu % 32;
      s_old  = m_mem[s_addr];
      if (m_we) m_mem[s_addr] = m_wdata;
      m_rd = s_old;
      refAlu(int'(operand1), sel3 ? int'(offset) : int'(operand2), int'(opcode), s_y, s_c);
      m_alu   = s_y;
      m_zero  = (s_y == 0);
      m_carry = s_c;
      m_wdata = int'(operand2);
      m_we    = w_r;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_result2", result2, sel1 ? m_alu : m_rd);
      checkOutput("model_zero", zero, m_zero);
      checkOutput("model_carry", carry, m_carry);
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    rst = 1'b1;
    applyStimulus(8'h00, 8'h00, 8'h00, OP_NOP, 1'b1, 1'b0, 1'b0);
    waitEdges(2);
    checkOutput("reset_result2", result2, 0);
    checkOutput("reset_zero", zero, 0);
    checkOutput("reset_carry", carry, 0);
    rst = 1'b0;
    check_en = 1'b1;

    applyStimulus(8'h03, 8'h02, 8'h00, OP_ADD, 1'b1, 1'b0, 1'b0);
    waitEdges(1);
    checkOutput("add_3_2", result2, 8'h05);
    checkOutput("add_3_2_zero", zero, 0);
    checkOutput("add_3_2_carry", carry, 0);

    applyStimulus(8'h01, 8'h02, 8'h00, OP_SUB, 1'b1, 1'b0, 1'b0);
    waitEdges(1);
    checkOutput("sub_1_2", result2, 8'hFF);
    checkOutput("sub_1_2_borrow", carry, 1);

    applyStimulus(8'h80, 8'h80, 8'h00, OP_ADD, 1'b1, 1'b0, 1'b0);
    waitEdges(1);
    checkOutput("add_80_80", result2, 8'h00);
    checkOutput("add_80_80_zero", zero, 1);
    checkOutput("add_80_80_carry", carry, 1);

    applyStimulus(8'h01, 8'hA5, 8'h04, OP_ADD, 1'b1, 1'b1, 1'b1);
    waitEdges(3);
    applyStimulus(8'h01, 8'hA5, 8'h04, OP_ADD, 1'b0, 1'b1, 1'b0);
    waitEdges(2);
    checkOutput("load_word5", result2, 8'hA5);

    applyStimulus(8'h1F, 8'h3C, 8'h03, OP_ADD, 1'b1, 1'b1, 1'b1);
    waitEdges(2);
    applyStimulus(8'h00, 8'h00, 8'h02, OP_ADD, 1'b0, 1'b1, 1'b0);
    waitEdges(2);
    checkOutput("load_wrap_word2", result2, 8'h3C);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      waitEdges(1);
    end

    rst = 1'b1;
    #1;
    checkOutput("midrun_rst_result2", result2, 0);
    checkOutput("midrun_rst_zero", zero, 0);
    checkOutput("midrun_rst_carry", carry, 0);
    waitEdges(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'($urandom), 8'h00, 8'h00, OP_PASSA, 1'b0, 1'b0, 1'b0);
      waitEdges(2);
      checkOutput("load_after_rst", result2, 0);
    end

    applyStimulus(8'h04, 8'h55, 8'h05, OP_ADD, 1'b1, 1'b1, 1'b1);
    waitEdges(2);
    applyStimulus(8'h04, 8'h55, 8'h05, OP_ADD, 1'b0, 1'b1, 1'b0);
    waitEdges(2);
    checkOutput("load_word9_before", result2, 8'h55);

    applyStimulus(8'h04, 8'h77, 8'h05, OP_ADD, 1'b1, 1'b1, 1'b1);
    waitEdges(1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("inflight_rst_result2", result2, 0);
    waitEdges(2);
    rst = 1'b0;
    applyStimulus(8'h04, 8'h00, 8'h05, OP_ADD, 1'b0, 1'b1, 1'b0);
    waitEdges(2);
    checkOutput("load_word9_after", result2, 0);
    applyStimulus(8'h00, 8'h00, 8'h00, OP_NOP, 1'b1, 1'b0, 1'b0);
    waitEdges(1);
    checkOutput("nop_result2", result2, 0);
    checkOutput("nop_carry", carry, 0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
